// File: rtl/fpu_fma_resp_queue_if.sv
// Handshake bundle between the FMA pipe output, the issue logic and the writeback arbiter.
// The slave modport is the response queue; the master modport is the surrounding pipeline.
interface fpu_fma_resp_queue_if #(
   parameter int DEPTH = 4
);
   localparam int INFLIGHT_W = $clog2(DEPTH + 1);

   logic                  issue_valid;
   logic                  issue_ready;
   logic                  pipe_out_valid;
   logic [64:0]           pipe_out_bits_data;
   logic [4:0]            pipe_out_bits_exc;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [64:0]           resp_bits_data;
   logic [4:0]            resp_bits_exc;
   logic [INFLIGHT_W-1:0] inflight;
   logic                  err;

   modport slave (
      input  issue_valid,
      output issue_ready,
      input  pipe_out_valid,
      input  pipe_out_bits_data,
      input  pipe_out_bits_exc,
      output resp_valid,
      input  resp_ready,
      output resp_bits_data,
      output resp_bits_exc,
      output inflight,
      output err
   );

   modport master (
      output issue_valid,
      input  issue_ready,
      output pipe_out_valid,
      output pipe_out_bits_data,
      output pipe_out_bits_exc,
      input  resp_valid,
      output resp_ready,
      input  resp_bits_data,
      input  resp_bits_exc,
      input  inflight,
      input  err
   );
endinterface

// File: rtl/fpu_fma_resp_queue.sv
// Credit-managed response FIFO behind the fixed-latency FMA pipe (no backpressure on the pipe).
// Optional sticky protocol-error flag is enabled by defining FPU_RESP_ERR_CHECK_EN.
module fpu_fma_resp_queue #(
   parameter int DEPTH = 4
) (
   input logic                 clock,
   input logic                 reset,
   fpu_fma_resp_queue_if.slave io
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int SUM_W = CNT_W + 1;

   typedef struct packed {
      logic [64:0] data;
      logic [4:0]  exc;
   } entry_t;

   generate
      if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
         $error("fpu_fma_resp_queue: DEPTH must be in 2..16");
      end
   endgenerate

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] inflight_q;

   logic issue_fire;
   logic push;
   logic pop;
   logic full;
   logic push_accept;

   // Pointers wrap explicitly so non-power-of-2 depths never index past the last entry.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Credits come from registered state only: a pop releases its slot one cycle later.
   assign io.issue_ready  = ({1'b0, count} + {1'b0, inflight_q}) < SUM_W'(DEPTH);
   assign io.resp_valid   = (count != '0);
   assign io.resp_bits_data = mem[rd_ptr].data;
   assign io.resp_bits_exc  = mem[rd_ptr].exc;
   assign io.inflight     = inflight_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      issue_fire  = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      full        = 1'b0;
      push_accept = 1'b0;

      issue_fire  = io.issue_valid & io.issue_ready;
      push        = io.pipe_out_valid;
      pop         = io.resp_valid & io.resp_ready;
      full        = (count == CNT_W'(DEPTH));
      push_accept = push & (~full | pop);
   end

   // NOTE: storage sits on the async reset because the head must read as zero after reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push_accept) begin
         // NOTE: sequential state always uses non-blocking assignments to avoid update races.
         mem[wr_ptr] <= '{data: io.pipe_out_bits_data, exc: io.pipe_out_bits_exc};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         inflight_q <= '0;
      end else begin
         if (push_accept) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end

         unique case ({push_accept, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         // An unsolicited return with nothing in flight leaves the counter parked at zero.
         unique case ({issue_fire, push})
            2'b10:   inflight_q <= inflight_q + CNT_W'(1);
            2'b01:   inflight_q <= (inflight_q != '0) ? inflight_q - CNT_W'(1) : '0;
            default: inflight_q <= inflight_q;
         endcase
      end
   end

`ifdef FPU_RESP_ERR_CHECK_EN
   logic err_q;
   logic overflow;
   logic unsolicited;

   assign overflow    = push & full & ~pop;
   assign unsolicited = push & (inflight_q == '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (overflow | unsolicited) begin
         err_q <= 1'b1;
      end
   end

   assign io.err = err_q;
`else
   assign io.err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_fma_resp_queue.sv
// Scoreboard bench for fpu_fma_resp_queue: DEPTH=4 and DEPTH=3 instances, 4-cycle pipe model.
// Expected beats are queued by the driver and consumed by an independent monitor process.
module tb_fpu_fma_resp_queue;
   localparam int LAT = 4;

`ifdef FPU_RESP_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct packed {
      logic [64:0] data;
      logic [4:0]  exc;
   } beat_t;

   logic clk;
   logic rst;

   // Per-instance stimulus and observation; index 0 is DEPTH=4, index 1 is DEPTH=3.
   logic        iv [2];
   logic        pv [2];
   logic        rr [2];
   logic [64:0] pd [2];
   logic [4:0]  pe [2];
   logic        ir [2];
   logic        rv [2];
   logic        er [2];
   logic [64:0] rd [2];
   logic [4:0]  re [2];
   logic [2:0]  infl [2];

   fpu_fma_resp_queue_if #(.DEPTH(4)) bus0 ();
   fpu_fma_resp_queue_if #(.DEPTH(3)) bus1 ();

   fpu_fma_resp_queue #(.DEPTH(4)) dut0 (.clock(clk), .reset(rst), .io(bus0.slave));
   fpu_fma_resp_queue #(.DEPTH(3)) dut1 (.clock(clk), .reset(rst), .io(bus1.slave));

   assign bus0.issue_valid        = iv[0];
   assign bus0.pipe_out_valid     = pv[0];
   assign bus0.pipe_out_bits_data = pd[0];
   assign bus0.pipe_out_bits_exc  = pe[0];
   assign bus0.resp_ready         = rr[0];
   assign ir[0]   = bus0.issue_ready;
   assign rv[0]   = bus0.resp_valid;
   assign er[0]   = bus0.err;
   assign rd[0]   = bus0.resp_bits_data;
   assign re[0]   = bus0.resp_bits_exc;
   assign infl[0] = bus0.inflight;

   assign bus1.issue_valid        = iv[1];
   assign bus1.pipe_out_valid     = pv[1];
   assign bus1.pipe_out_bits_data = pd[1];
   assign bus1.pipe_out_bits_exc  = pe[1];
   assign bus1.resp_ready         = rr[1];
   assign ir[1]   = bus1.issue_ready;
   assign rv[1]   = bus1.resp_valid;
   assign er[1]   = bus1.err;
   assign rd[1]   = bus1.resp_bits_data;
   assign re[1]   = bus1.resp_bits_exc;
   assign infl[1] = {1'b0, bus1.inflight};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: occupancy, outstanding ops, sticky error, expected beats, pipe returns.
   int    act = 0;
   int    cyc = 0;
   int    seq = 1;
   int    m_count = 0;
   int    m_inflight = 0;
   bit    m_err = 1'b0;
   int    n_resp = 0;
   int    n_issued = 0;
   int    n_dut_fire = 0;
   beat_t exp_q [$];
   int    due [$];

   function automatic int dep();
      return (act == 0) ? 4 : 3;
   endfunction

   task automatic check(input string name, input logic [69:0] got, input logic [69:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b0;
         pv[k] = 1'b0;
         rr[k] = 1'b0;
         pd[k] = '0;
         pe[k] = '0;
      end
   endtask

   // One clock of stimulus: drive at negedge, check registered outputs, then advance the model.
   task automatic step(input bit want_issue, input bit want_ready, input bit extra, input bit use_seq);
      bit    due_hit;
      bit    push;
      bit    fire_i;
      bit    pop;
      bit    acc;
      beat_t b;
      @(negedge clk);
      due_hit = (due.size() != 0) && (due[0] == cyc);
      if (due_hit) void'(due.pop_front());
      push = due_hit || extra;
      b = '0;
      if (push) begin
         if (use_seq) begin
            b.data = 65'(seq);
            b.exc  = 5'(seq);
         end else begin
            b.data = {1'($urandom()), 32'($urandom()), 32'($urandom())};
            b.exc  = 5'($urandom());
         end
         seq++;
      end
      iv[act] = want_issue;
      pv[act] = push;
      pd[act] = b.data;
      pe[act] = b.exc;
      rr[act] = want_ready;
      #1;
      check($sformatf("issue_ready[%0d]", act), 70'(ir[act]), 70'((m_count + m_inflight) < dep()));
      check($sformatf("resp_valid[%0d]", act), 70'(rv[act]), 70'(m_count != 0));
      check($sformatf("inflight[%0d]", act), 70'(infl[act]), 70'(m_inflight));
      check($sformatf("err[%0d]", act), 70'(er[act]), 70'(m_err));
      if (iv[act] && ir[act]) n_dut_fire++;

      fire_i = want_issue && ((m_count + m_inflight) < dep());
      pop    = want_ready && (m_count != 0);
      acc    = push && ((m_count < dep()) || pop);
      if (fire_i) begin
         due.push_back(cyc + LAT);
         n_issued++;
      end
      @(posedge clk);
      #1;
      if (ERR_EN && push && (((m_count == dep()) && !pop) || (m_inflight == 0))) m_err = 1'b1;
      m_count = m_count + (acc ? 1 : 0) - (pop ? 1 : 0);
      if (fire_i && !push) m_inflight++;
      else if (push && !fire_i && m_inflight > 0) m_inflight--;
      if (acc) exp_q.push_back(b);
      cyc++;
   endtask

   // Asserts reset between clock edges and checks outputs before any edge arrives.
   task automatic apply_reset();
      @(negedge clk);
      idle_inputs();
      #3 rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_resp_valid[%0d]", k), 70'(rv[k]), 70'(0));
         check($sformatf("rst_issue_ready[%0d]", k), 70'(ir[k]), 70'(1));
         check($sformatf("rst_inflight[%0d]", k), 70'(infl[k]), 70'(0));
         check($sformatf("rst_resp_data[%0d]", k), 70'(rd[k]), 70'(0));
         check($sformatf("rst_resp_exc[%0d]", k), 70'(re[k]), 70'(0));
         check($sformatf("rst_err[%0d]", k), 70'(er[k]), 70'(0));
      end
      exp_q.delete();
      due.delete();
      m_count = 0;
      m_inflight = 0;
      m_err = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain();
      int i;
      i = 0;
      while ((exp_q.size() != 0 || m_inflight != 0 || due.size() != 0) && i < 80) begin
         step(1'b0, 1'b1, 1'b0, 1'b1);
         i++;
      end
      check($sformatf("drained[%0d]", act), 70'(exp_q.size()), 70'(0));
   endtask

   // Monitor: whenever the active DUT hands over a beat, pop and compare the scoreboard head.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && rv[act] && rr[act]) begin
            if (exp_q.size() == 0) begin
               n_total++;
               n_bad++;
               $display("FAIL resp_unexpected[%0d]: got data %0h with nothing expected", act, rd[act]);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("resp_data[%0d]", act), 70'(rd[act]), 70'(e.data));
               check($sformatf("resp_exc[%0d]", act), 70'(re[act]), 70'(e.exc));
               n_resp++;
            end
         end
      end
   end

   initial begin
      int start;
      int i;
      rst = 1'b0;
      idle_inputs();
      apply_reset();

      // Credit exhaustion: four issues then blocked, beats 1..4 come out in order.
      act = 0;
      seq = 1;
      n_dut_fire = 0;
      repeat (12) step(1'b1, 1'b0, 1'b0, 1'b1);
      check("credit_fires", 70'(n_dut_fire), 70'(4));
      check("credit_blocked", 70'(ir[0]), 70'(0));
      check("credit_resp_valid", 70'(rv[0]), 70'(1));
      drain();

      // Mid-stream reset with two beats queued and one still in the pipe.
      seq = 1;
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
      i = 0;
      while (!(m_count == 2 && m_inflight == 1) && i < 20) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         i++;
      end
      check("midreset_setup", 70'(rv[0]), 70'(1));
      apply_reset();

      // Streaming: both handshakes held high until 100 responses have drained.
      start = n_resp;
      i = 0;
      while ((n_resp - start) < 100 && i < 1000) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         i++;
      end
      check("stream_count", 70'(n_resp - start), 70'(100));
      drain();

      // Full queue: overflow with no pop is dropped, push with a same-cycle pop is kept.
      apply_reset();
      seq = 1;
      repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1);
      i = 0;
      while (m_count != 4 && i < 20) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         i++;
      end
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("full_still_full", 70'(ir[0]), 70'(0));
      drain();

      // Unsolicited return into an empty queue.
      apply_reset();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("unsol_inflight", 70'(infl[0]), 70'(0));
      check("unsol_err", 70'(er[0]), 70'(ERR_EN));
      drain();

      // DEPTH=3: ten beats through a wrapping queue, exc 1..10 in order.
      apply_reset();
      act = 1;
      seq = 1;
      n_issued = 0;
      start = n_resp;
      i = 0;
      while ((n_resp - start) < 10 && i < 200) begin
         step(n_issued < 10, 1'b1, 1'b0, 1'b1);
         i++;
      end
      check("d3_count", 70'(n_resp - start), 70'(10));
      drain();

      // Random mix on both depths.
      for (int k = 0; k < 2; k++) begin
         apply_reset();
         act = k;
         repeat (250) step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 55, 1'b0, 1'b0);
         drain();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
